// File: rtl/vga_scan_engine.sv
// VGA raster timing generator with a multiplier-free, power-of-two down-scaling address walker.
// Sync, blank and frame markers are delayed to line up with colour returned by video memory.
module vga_scan_engine #(
  parameter int unsigned H_ACTIVE                = 640,
  parameter int unsigned H_FP                    = 16,
  parameter int unsigned H_SYNC                  = 96,
  parameter int unsigned H_BP                    = 48,
  parameter int unsigned V_ACTIVE                = 480,
  parameter int unsigned V_FP                    = 10,
  parameter int unsigned V_SYNC                  = 2,
  parameter int unsigned V_BP                    = 33,
  parameter bit          HS_POL                  = 1'b0,
  parameter bit          VS_POL                  = 1'b0,
  parameter int unsigned SCALE_LOG2              = 2,
  parameter int unsigned BITS_PER_COLOUR_CHANNEL = 4,
  parameter int unsigned MEM_LATENCY             = 1,
  parameter int unsigned ADDR_WIDTH              = 15
) (
  input  logic                                   vga_clock,
  input  logic                                   resetn,
  input  logic [3*BITS_PER_COLOUR_CHANNEL-1:0]   pixel_colour,
  output logic [ADDR_WIDTH-1:0]                  memory_address,
  output logic [9:0]                             VGA_R,
  output logic [9:0]                             VGA_G,
  output logic [9:0]                             VGA_B,
  output logic                                   VGA_HS,
  output logic                                   VGA_VS,
  output logic                                   VGA_BLANK,
  output logic                                   VGA_SYNC,
  output logic                                   VGA_CLK,
  output logic                                   frame_start,
  output logic                                   vblank
);

  localparam int unsigned BPC     = BITS_PER_COLOUR_CHANNEL;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned XW      = $clog2(H_TOTAL);
  localparam int unsigned YW      = $clog2(V_TOTAL);
  localparam int unsigned STRIDE  = H_ACTIVE >> SCALE_LOG2;

  localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT      = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_FIRST   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_LAST    = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT      = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_ACT_LAST = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] VS_FIRST   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_LAST    = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [YW-1:0] ROW_MASK   = YW'((1 << SCALE_LOG2) - 1);

  // Alignment pipeline payload bit positions; idle = inactive, no syncs, no frame_start, vblank
  localparam int unsigned P_ACT = 4;
  localparam int unsigned P_HS  = 3;
  localparam int unsigned P_VS  = 2;
  localparam int unsigned P_FS  = 1;
  localparam int unsigned P_VB  = 0;
  localparam int unsigned PW    = 5;
  localparam logic [PW-1:0] STAGE_IDLE = PW'(5'b00001);

  logic [XW-1:0]              x_counter;
  logic [YW-1:0]              y_counter;
  logic [ADDR_WIDTH-1:0]      row_base;
  logic [MEM_LATENCY*PW-1:0]  pipe;

  logic                       x_wrap_c;
  logic                       y_wrap_c;
  logic                       row_step_c;
  logic [YW-1:0]              y_plus1_c;
  logic [PW-1:0]              stage_c;
  logic [PW-1:0]              aligned_c;
  logic [9:0]                 r_exp_c;
  logic [9:0]                 g_exp_c;
  logic [9:0]                 b_exp_c;

  // Raster decode and address generation from the current scan position
  always_comb begin
    x_wrap_c       = 1'b0;
    y_wrap_c       = 1'b0;
    row_step_c     = 1'b0;
    y_plus1_c      = '0;
    stage_c        = STAGE_IDLE;
    memory_address = '0;

    x_wrap_c   = (x_counter == X_LAST);
    y_wrap_c   = (y_counter == Y_LAST);
    y_plus1_c  = y_counter + YW'(1);
    row_step_c = (y_counter < Y_ACT_LAST) && ((y_plus1_c & ROW_MASK) == '0);

    stage_c[P_ACT] = (x_counter < X_ACT) && (y_counter < Y_ACT);
    stage_c[P_HS]  = (x_counter >= HS_FIRST) && (x_counter <= HS_LAST);
    stage_c[P_VS]  = (y_counter >= VS_FIRST) && (y_counter <= VS_LAST);
    stage_c[P_FS]  = (x_counter == '0) && (y_counter == '0);
    stage_c[P_VB]  = (y_counter >= Y_ACT);

    if (stage_c[P_ACT]) begin
      memory_address = row_base + ADDR_WIDTH'(x_counter >> SCALE_LOG2);
    end
  end

  // Scan counters; row_base advances by one stride every 2^SCALE_LOG2 visible lines
  always_ff @(posedge vga_clock) begin
    if (!resetn) begin
      x_counter <= '0;
      y_counter <= '0;
      row_base  <= '0;
    end else if (x_wrap_c) begin
      x_counter <= '0;
      if (y_wrap_c) begin
        y_counter <= '0;
        row_base  <= '0;
      end else begin
        y_counter <= y_plus1_c;
        if (row_step_c) begin
          row_base <= row_base + ADDR_WIDTH'(STRIDE);
        end
      end
    end else begin
      x_counter <= x_counter + XW'(1);
    end
  end

  // Delay raster markers by the memory read latency
  if (MEM_LATENCY == 1) begin : g_pipe_single
    always_ff @(posedge vga_clock) begin
      if (!resetn) begin
        pipe <= STAGE_IDLE;
      end else begin
        pipe <= stage_c;
      end
    end
  end else begin : g_pipe_multi
    always_ff @(posedge vga_clock) begin
      if (!resetn) begin
        pipe <= {MEM_LATENCY{STAGE_IDLE}};
      end else begin
        pipe <= {pipe[(MEM_LATENCY-1)*PW-1:0], stage_c};
      end
    end
  end

  assign aligned_c = pipe[MEM_LATENCY*PW-1 -: PW];

  // Replicate each channel's MSB-first bit pattern across the 10-bit DAC word
  for (genvar i = 0; i < 10; i++) begin : g_expand
    assign r_exp_c[9-i] = pixel_colour[2*BPC + BPC - 1 - (i % BPC)];
    assign g_exp_c[9-i] = pixel_colour[BPC + BPC - 1 - (i % BPC)];
    assign b_exp_c[9-i] = pixel_colour[BPC - 1 - (i % BPC)];
  end

  // Output registers: colour and markers leave together
  always_ff @(posedge vga_clock) begin
    if (!resetn) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_BLANK   <= 1'b0;
      frame_start <= 1'b0;
      vblank      <= 1'b1;
    end else begin
      VGA_R       <= aligned_c[P_ACT] ? r_exp_c : '0;
      VGA_G       <= aligned_c[P_ACT] ? g_exp_c : '0;
      VGA_B       <= aligned_c[P_ACT] ? b_exp_c : '0;
      VGA_HS      <= aligned_c[P_HS] ? HS_POL : ~HS_POL;
      VGA_VS      <= aligned_c[P_VS] ? VS_POL : ~VS_POL;
      VGA_BLANK   <= aligned_c[P_ACT];
      frame_start <= aligned_c[P_FS];
      vblank      <= aligned_c[P_VB];
    end
  end

  assign VGA_SYNC = 1'b1;
  assign VGA_CLK  = vga_clock;

endmodule
